// File: rtl/gbc_pak_bus_sequencer_if.sv
// Request/response and GamePak pin bundle for the pak bus sequencer.
// The master side is the sequencer, which answers requests and drives the pak
// pins. The slave side is the requester and cartridge model. All pak strobes
// are active-high here.
interface gbc_pak_bus_sequencer_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [7:0]  ReqData;
    logic        RspValid;
    logic [7:0]  RspData;
    logic        PakResetReq;
    logic        PakClk;
    logic        PakRead;
    logic        PakWrite;
    logic        PakCS;
    logic [15:0] PakAddress;
    logic [7:0]  PakDToPak;
    logic        PakDOE;
    logic [7:0]  PakDFromPak;
    logic        PakReset;

    modport master (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, PakResetReq, PakDFromPak,
        output ReqReady, RspValid, RspData,
        output PakClk, PakRead, PakWrite, PakCS, PakAddress, PakDToPak, PakDOE, PakReset
    );

    modport slave (
        output ReqValid, ReqWrite, ReqAddr, ReqData, PakResetReq, PakDFromPak,
        input  ReqReady, RspValid, RspData,
        input  PakClk, PakRead, PakWrite, PakCS, PakAddress, PakDToPak, PakDOE, PakReset
    );
endinterface

// File: rtl/gbc_pak_bus_sequencer.sv
// GamePak bus sequencer. It turns single-byte requests into three-phase
// cartridge cycles: ADDR (PakClk high), STROBE (RD/WR), and RELEASE (hold).
// Each phase is PHASE_CLKS system clocks long. The block also holds the
// cartridge in reset after power-up and after a soft-reset request.
module gbc_pak_bus_sequencer #(
    parameter int PHASE_CLKS = 4,
    parameter int RESET_CLKS = 64
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    gbc_pak_bus_sequencer_if.master  bus
);
    localparam int MAXC = (PHASE_CLKS > RESET_CLKS) ? PHASE_CLKS : RESET_CLKS;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PH_LOAD = CW'(PHASE_CLKS - 1);
    localparam logic [CW-1:0] RS_LOAD = CW'(RESET_CLKS - 1);
    localparam bit            RS_ONE  = (RESET_CLKS == 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_RELEASE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            wr_q, cs_q;
    logic [15:0]     addr_q;
    logic [7:0]      dout_q, rsp_q;
    logic            req_ready, accept, capture, rsp_valid;
    logic            phase_done, reset_done, in_txn;

    assign phase_done = (cnt == '0);
    // A counter value of 0 in RESET_HOLD means "just entered". This lets the
    // async-cleared counter and the soft-reset entry share one path. The
    // counter is reloaded to RESET_CLKS-1 on the first hold clock, and the
    // hold ends when the counter reaches 1.
    assign reset_done = RS_ONE || (cnt == CW'(1));

    // State register and phase/reset down-counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_RESET_HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter reload, and handshake decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_RESET_HOLD: begin
                if (reset_done) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = (cnt == '0) ? RS_LOAD : cnt - CW'(1);
                end
            end
            S_IDLE: begin
                req_ready = !bus.PakResetReq;
                if (bus.PakResetReq) begin
                    state_nxt = S_RESET_HOLD;
                    cnt_nxt   = '0;
                end else if (bus.ReqValid) begin
                    accept    = 1'b1;
                    state_nxt = S_ADDR;
                    cnt_nxt   = PH_LOAD;
                end
            end
            S_ADDR: begin
                if (phase_done) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = PH_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_STROBE: begin
                capture = phase_done && !wr_q;
                if (phase_done) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = PH_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_RELEASE: begin
                rsp_valid = (cnt == PH_LOAD);
                if (phase_done) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = S_RESET_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Latch request fields at accept. Capture read data on the last STROBE clock.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_q   <= 1'b0;
            cs_q   <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
            rsp_q  <= '0;
        end else begin
            if (accept) begin
                wr_q   <= bus.ReqWrite;
                cs_q   <= (bus.ReqAddr[15:13] == 3'b101);
                addr_q <= bus.ReqAddr;
                if (bus.ReqWrite) dout_q <= bus.ReqData;
            end
            if (capture) rsp_q <= bus.PakDFromPak;
        end
    end

    // Pak strobes are decoded from state. An async reset therefore drops them immediately.
    assign in_txn         = (state == S_ADDR) || (state == S_STROBE);
    assign bus.PakClk     = (state == S_ADDR);
    assign bus.PakCS      = in_txn && cs_q;
    assign bus.PakRead    = in_txn && !wr_q;
    assign bus.PakWrite   = (state == S_STROBE) && wr_q;
    assign bus.PakDOE     = (in_txn || (state == S_RELEASE)) && wr_q;
    assign bus.PakReset   = (state == S_RESET_HOLD);
    assign bus.PakAddress = addr_q;
    assign bus.PakDToPak  = dout_q;
    assign bus.ReqReady   = req_ready;
    assign bus.RspValid   = rsp_valid;
    assign bus.RspData    = rsp_q;
endmodule

// File: tb/tb_gbc_pak_bus_sequencer.sv
// Directed bench for gbc_pak_bus_sequencer. u4 uses PHASE_CLKS=4 and
// RESET_CLKS=64. u1 uses PHASE_CLKS=1 and RESET_CLKS=4 for the back-to-back
// throughput case. The bench drives inputs and samples outputs on the falling
// edge of Clk.
module tb_gbc_pak_bus_sequencer;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 Clk = ~Clk;

    gbc_pak_bus_sequencer_if bus4();
    gbc_pak_bus_sequencer_if bus1();

    gbc_pak_bus_sequencer #(.PHASE_CLKS(4), .RESET_CLKS(64)) u4 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus4.master));
    gbc_pak_bus_sequencer #(.PHASE_CLKS(1), .RESET_CLKS(4)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus1.master));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge where Reset_n has just been released.
    // Expect 64 clocks of hold, then IDLE.
    task automatic hold_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 63; i++) begin
            @(negedge Clk);
            if (bus4.PakReset !== 1'b1 || bus4.ReqReady !== 1'b0 || bus4.RspValid !== 1'b0 ||
                bus4.PakRead !== 1'b0 || bus4.PakWrite !== 1'b0 || bus4.PakCS !== 1'b0 ||
                bus4.PakDOE !== 1'b0 || bus4.PakClk !== 1'b0) bad++;
        end
        chk({tag, "/hold"}, 16'(bad), 16'd0);
        @(negedge Clk);
        chk({tag, "/rst_end"}, 16'(bus4.PakReset), 16'd0);
        chk({tag, "/ready"}, 16'(bus4.ReqReady), 16'd1);
    endtask

    // One full u4 transaction, starting at a negedge with u4 in IDLE.
    // Obs j is the negedge after accept edge + j.
    task automatic run_txn(input string tag, input bit wr, input logic [15:0] addr,
                           input logic [7:0] data, input logic [7:0] pakd,
                           input logic [7:0] exp_rsp, input int rr_at);
        bit cs;
        cs = (addr[15:13] == 3'b101);
        bus4.ReqValid = 1'b1;
        bus4.ReqWrite = wr;
        bus4.ReqAddr = addr;
        bus4.ReqData = data;
        bus4.PakDFromPak = 8'hEE;
        for (int j = 0; j <= 12; j++) begin
            @(negedge Clk);
            if (j == 0) begin
                bus4.ReqValid = 1'b0;
                bus4.ReqWrite = !wr;
                bus4.ReqAddr = 16'hFFFF;
                bus4.ReqData = 8'h00;
            end
            chk({tag, "/clk"},   16'(bus4.PakClk),   16'(j < 4));
            chk({tag, "/rd"},    16'(bus4.PakRead),  16'((j < 8) && !wr));
            chk({tag, "/wr"},    16'(bus4.PakWrite), 16'(wr && j >= 4 && j < 8));
            chk({tag, "/cs"},    16'(bus4.PakCS),    16'((j < 8) && cs));
            chk({tag, "/doe"},   16'(bus4.PakDOE),   16'(wr && j < 12));
            chk({tag, "/rspv"},  16'(bus4.RspValid), 16'(j == 8));
            chk({tag, "/ready"}, 16'(bus4.ReqReady), 16'((j == 12) && (rr_at < 0)));
            chk({tag, "/addr"},  bus4.PakAddress,    addr);
            if (wr) chk({tag, "/dout"}, 16'(bus4.PakDToPak), 16'(data));
            if (j >= 8) chk({tag, "/rspd"}, 16'(bus4.RspData), 16'(exp_rsp));
            if (j == 3) bus4.PakDFromPak = pakd;
            if (j == 8) bus4.PakDFromPak = 8'hEE;
            if (j == rr_at) begin
                bus4.PakResetReq = 1'b1;
                bus4.ReqValid = 1'b1;
                bus4.ReqWrite = 1'b0;
                bus4.ReqAddr = 16'h0200;
            end
        end
    endtask

    initial begin
        logic [15:0] a [3];
        logic [7:0]  d [3];
        int bad;
        a[0] = 16'h0150; a[1] = 16'hA123; a[2] = 16'h7FFF;
        d[0] = 8'h11;    d[1] = 8'hA5;    d[2] = 8'hF0;
        bus4.ReqValid = 0; bus4.ReqWrite = 0; bus4.ReqAddr = 0; bus4.ReqData = 0;
        bus4.PakResetReq = 0; bus4.PakDFromPak = 0;
        bus1.ReqValid = 0; bus1.ReqWrite = 0; bus1.ReqAddr = 0; bus1.ReqData = 0;
        bus1.PakResetReq = 0; bus1.PakDFromPak = 0;

        // Reset state.
        @(negedge Clk);
        chk("rst/pakreset", 16'(bus4.PakReset), 16'd1);
        chk("rst/ready",    16'(bus4.ReqReady), 16'd0);
        chk("rst/rspv",     16'(bus4.RspValid), 16'd0);
        chk("rst/clk",      16'(bus4.PakClk),   16'd0);
        chk("rst/addr",     bus4.PakAddress,    16'h0000);
        chk("rst/rspd",     16'(bus4.RspData),  16'h00);
        chk("rst/u1",       16'(bus1.PakReset), 16'd1);
        Reset_n = 1'b1;
        hold_check("por");

        // Plain read, write, and chip-selected read.
        run_txn("rd0150", 1'b0, 16'h0150, 8'h00, 8'h3C, 8'h3C, -1);
        run_txn("wrA000", 1'b1, 16'hA000, 8'h5A, 8'h77, 8'h3C, -1);
        run_txn("rdB123", 1'b0, 16'hB123, 8'h00, 8'hC5, 8'hC5, -1);

        // Soft reset requested during ADDR: the read completes, then a 64-clock hold.
        run_txn("rstreq", 1'b0, 16'h4000, 8'h00, 8'h81, 8'h81, 1);
        bad = 0;
        for (int j = 13; j <= 76; j++) begin
            @(negedge Clk);
            if (bus4.PakReset !== 1'b1 || bus4.ReqReady !== 1'b0 ||
                bus4.PakRead !== 1'b0 || bus4.RspValid !== 1'b0) bad++;
            if (j == 40) bus4.PakResetReq = 1'b0;
        end
        chk("rstreq/hold", 16'(bad), 16'd0);
        @(negedge Clk);
        chk("rstreq/rst_end", 16'(bus4.PakReset), 16'd0);
        chk("rstreq/ready",   16'(bus4.ReqReady), 16'd1);
        @(negedge Clk);
        bus4.ReqValid = 1'b0;
        chk("rstreq/acc_rd",   16'(bus4.PakRead), 16'd1);
        chk("rstreq/acc_addr", bus4.PakAddress,   16'h0200);
        for (int j = 0; j < 12; j++) @(negedge Clk);
        chk("rstreq/done", 16'(bus4.ReqReady), 16'd1);

        // Reset_n pulsed low during STROBE of a write.
        bus4.ReqValid = 1'b1; bus4.ReqWrite = 1'b1;
        bus4.ReqAddr = 16'hA010; bus4.ReqData = 8'h99;
        for (int j = 0; j <= 5; j++) begin
            @(negedge Clk);
            if (j == 0) bus4.ReqValid = 1'b0;
        end
        chk("abort/pre_wr", 16'(bus4.PakWrite), 16'd1);
        Reset_n = 1'b0;
        #1;
        chk("abort/wr",  16'(bus4.PakWrite), 16'd0);
        chk("abort/cs",  16'(bus4.PakCS),    16'd0);
        chk("abort/doe", 16'(bus4.PakDOE),   16'd0);
        chk("abort/res", 16'(bus4.PakReset), 16'd1);
        @(negedge Clk);
        chk("abort/rspv", 16'(bus4.RspValid), 16'd0);
        chk("abort/rspd", 16'(bus4.RspData),  16'h00);
        Reset_n = 1'b1;
        hold_check("abort");

        // PHASE_CLKS=1: three back-to-back reads with ReqValid held high.
        bus1.ReqValid = 1'b1; bus1.ReqWrite = 1'b0; bus1.ReqAddr = a[0];
        chk("b2b/ready0", 16'(bus1.ReqReady), 16'd1);
        for (int n = 1; n <= 12; n++) begin
            int t;
            @(negedge Clk);
            t = (n - 1) / 4;
            chk("b2b/rspv",  16'(bus1.RspValid), 16'(n % 4 == 3));
            chk("b2b/ready", 16'(bus1.ReqReady), 16'(n % 4 == 0));
            chk("b2b/rd",    16'(bus1.PakRead),  16'(n % 4 == 1 || n % 4 == 2));
            if (n % 4 == 1) begin
                chk("b2b/addr", bus1.PakAddress, a[t]);
                chk("b2b/cs",   16'(bus1.PakCS), 16'(t == 1));
                bus1.PakDFromPak = d[t];
                if (t < 2) bus1.ReqAddr = a[t + 1];
                else bus1.ReqValid = 1'b0;
            end
            if (n % 4 == 3) chk("b2b/rspd", 16'(bus1.RspData), 16'(d[t]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gbc_pak_bus_sequencer.md
Name: gbc_pak_bus_sequencer

Overview:
- Sits directly upstream of the GamePak pin interface (Controller side): converts single-byte CPU/MMU requests into timed cartridge bus cycles.
- Drives PakClk, PakRead, PakWrite, PakCS, address and data, plus the cartridge reset.
- Returns read data with a one-clock completion pulse.
- Pin polarity inversion (/RD, /WR, /CS, /RES) is done at the I/O pads; all pak-side signals here are active-high.

Parameters:
- PHASE_CLKS, 4, system clocks per bus phase (>=1); one pak cycle = 3 phases.
- RESET_CLKS, 64, system clocks PakReset is held after reset release or a soft-reset request (>=1).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  request accepted when ReqValid&&ReqReady at rising Clk.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  16  pak address.
- ReqData  in  8  write data.
- RspValid  out  1  one-clock completion pulse (reads and writes).
- RspData  out  8  last read byte.
- PakResetReq  in  1  soft cartridge reset request (level).
- PakClk, PakRead, PakWrite, PakCS  out  1 each  pak strobes.
- PakAddress  out  16  pak address bus.
- PakDToPak  out  8  write data.
- PakDOE  out  1  data output enable.
- PakDFromPak  in  8  read data.
- PakReset  out  1  cartridge reset.

Behaviour:
- Async reset (Reset_n=0): all outputs 0 except PakReset=1; state RESET_HOLD, counter cleared.
- States: RESET_HOLD, IDLE, ADDR, STROBE, RELEASE. One down-counter, width clog2(max(PHASE_CLKS,RESET_CLKS)+1).
- RESET_HOLD: PakReset=1, ReqReady=0, all strobes 0. Lasts RESET_CLKS clocks, then IDLE with PakReset=0.
- IDLE: ReqReady=1 only when PakResetReq=0. If PakResetReq=1 -> RESET_HOLD (ReqReady=0 that clock).
- On accept: latch addr/data/write; PakAddress=addr; PakDToPak=data for writes; go ADDR.
- ADDR (PHASE_CLKS clocks):
  - PakClk=1.
  - PakCS=1 iff addr in 0xA000-0xBFFF (addr[15:13]==3'b101).
  - PakRead=~write; PakWrite=0; PakDOE=write.
- STROBE (PHASE_CLKS clocks):
  - PakClk=0; CS/Read/DOE as in ADDR; PakWrite=write.
  - For reads, PakDFromPak is registered into RspData on the last STROBE clock.
- RELEASE (PHASE_CLKS clocks):
  - PakRead=0, PakWrite=0, PakCS=0, PakClk=0.
  - PakAddress and PakDToPak held; PakDOE held for writes (data hold), dropped on exit.
  - RspValid=1 in the first RELEASE clock only. Then IDLE.
- Latency: accept at edge k; RspValid high in the clock after edge k+2*PHASE_CLKS. ReqReady high again after 3*PHASE_CLKS clocks.
- Throughput: at most one transaction per 3*PHASE_CLKS+1 clocks.
- RspData is unchanged by writes and keeps its last read value until the next read.
- PakAddress is unchanged in IDLE (holds last address).
- PakResetReq asserted mid-transaction: the transaction completes normally (RspValid issued), then IDLE -> RESET_HOLD. No request is accepted while PakResetReq=1.
- Reset_n asserted mid-transaction: immediate return to reset values, no RspValid. The pending request is dropped and the requester must reissue.
- ReqValid dropped without acceptance: no effect. Request fields are only sampled at accept.

Test Plan:
- Reset release, PHASE_CLKS=4, RESET_CLKS=64 -> PakReset=1 and ReqReady=0 for exactly 64 clocks after Reset_n rises; then PakReset=0, ReqReady=1.
- Read 0x0150, pak drives 0x3C during STROBE:
  - PakCS=0, PakRead=1 for 8 clocks, PakClk high 4 / low 4.
  - RspValid one clock at accept+9 with RspData=0x3C; ReqReady back at accept+13.
- Write 0xA000 data 0x5A:
  - PakCS=1 for 8 clocks, PakWrite=1 only in STROBE.
  - PakDOE=1 for 12 clocks, PakDToPak=0x5A throughout; RspValid pulse; RspData unchanged.
- PakResetReq raised in ADDR of a read -> read completes with RspValid, then PakReset=1 for 64 clocks. ReqValid held high is not accepted until PakResetReq=0 and the hold ends.
- PHASE_CLKS=1, ReqValid held with 3 back-to-back reads -> accepts spaced exactly 4 clocks apart, 3 RspValid pulses, each RspData matching the pak data.
- Reset_n pulsed low during STROBE of a write -> PakWrite, PakCS, PakDOE drop asynchronously; no RspValid; RESET_HOLD restarts the full 64 clocks.
